// File: rtl/controlador_bombas_pkg.sv
// Shared types and helpers for the cascade pump controller.
// Pump state encoding and counter width sizing.
package controlador_bombas_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    LOCK = 2'd2
  } pump_st_t;

  // Width able to hold 0..v-1, never below 1 bit.
  function automatic int cw(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int deb_w(input int deb_cycles);
    return cw(deb_cycles);
  endfunction

  function automatic int lock_w(input int min_off);
    return cw(min_off);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Single-bit level sensor conditioner.
// Two-flop synchroniser followed by a stability debouncer.
module sensor_debounce
  import controlador_bombas_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic d_out
);

  localparam int CW = deb_w(DEB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Synchronise, then accept a new level only after it persists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      d_out <= 1'b0;
    end else begin
      s1 <= d_in;
      s2 <= s1;
      if (s2 == d_out) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        d_out <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/controlador_bombas_param.sv
// N-tank cascade pump controller.
// Debounced sensing, hysteresis demand, sticky faults, min-off lockout.
module controlador_bombas_param
  import controlador_bombas_pkg::*;
#(
  parameter int N_TANKS    = 2,
  parameter int DEB_CYCLES = 4,
  parameter int MIN_OFF    = 8,
  parameter int HYST       = 1,
  parameter int FAULT_ALL  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               src_ok,
  input  logic [N_TANKS-1:0] s_low,
  input  logic [N_TANKS-1:0] s_high,
  input  logic               fault_clr,
  output logic [N_TANKS-1:0] pump,
  output logic [N_TANKS-1:0] fault
);

  localparam int LW   = lock_w(MIN_OFF);
  localparam int LOAD = (MIN_OFF > 0) ? MIN_OFF - 1 : 0;

  logic [N_TANKS-1:0] dl;
  logic [N_TANKS-1:0] dh;
  logic [N_TANKS-1:0] cond;
  logic [N_TANKS-1:0] fe;
  logic [N_TANKS-1:0] dem;
  logic [N_TANKS-1:0] dem_r;
  logic [N_TANKS-1:0] src;
  logic [N_TANKS-1:0] blk;
  logic [N_TANKS-1:0] ok;
  logic [N_TANKS-1:0] fault_q;

  for (genvar g = 0; g < N_TANKS; g++) begin : g_sens
    sensor_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_low (
      .clk  (clk),
      .rst_n(rst_n),
      .d_in (s_low[g]),
      .d_out(dl[g])
    );
    sensor_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_high (
      .clk  (clk),
      .rst_n(rst_n),
      .d_in (s_high[g]),
      .d_out(dh[g])
    );
  end

  // Per-tank run permission from levels, faults and upstream supply.
  always_comb begin
    cond = dh & ~dl;
    fe   = fault_q | cond;
    if (HYST != 0) dem = (dem_r | ~dl) & ~dh;
    else           dem = ~dh;
    src    = dl;
    src    = src << 1;
    src[0] = src_ok;
    if (FAULT_ALL != 0) blk = {N_TANKS{|fe}};
    else                blk = fe | (fe << 1);
    ok = {N_TANKS{en}} & dem & src & ~blk;
  end

  // Sticky faults and hysteresis memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= '0;
      dem_r   <= '0;
    end else begin
      fault_q <= cond | (fault_q & ~{N_TANKS{fault_clr}});
      dem_r   <= dem;
    end
  end

  assign fault = fault_q;

  for (genvar p = 0; p < N_TANKS; p++) begin : g_pump
    pump_st_t     st_q;
    pump_st_t     st_n;
    logic [LW-1:0] cnt_q;
    logic [LW-1:0] cnt_n;
    logic         run_q;

    // Pump state transitions and lockout countdown.
    always_comb begin
      st_n  = st_q;
      cnt_n = cnt_q;
      case (st_q)
        OFF: begin
          if (ok[p]) st_n = RUN;
        end
        RUN: begin
          if (!ok[p]) begin
            if (MIN_OFF == 0) begin
              st_n = OFF;
            end else begin
              st_n  = LOCK;
              cnt_n = LW'(LOAD);
            end
          end
        end
        LOCK: begin
          if (cnt_q == '0) st_n = OFF;
          else             cnt_n = cnt_q - LW'(1);
        end
        default: st_n = OFF;
      endcase
    end

    // State register with registered motor drive.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q  <= OFF;
        cnt_q <= '0;
        run_q <= 1'b0;
      end else begin
        st_q  <= st_n;
        cnt_q <= cnt_n;
        run_q <= (st_n == RUN);
      end
    end

    assign pump[p] = run_q;
  end

endmodule

// File: tb/tb_controlador_bombas_param.sv
// Bench for the cascade pump controller.
// Directed plan steps plus random stimulus against a cycle model.
module tb_controlador_bombas_param;

  localparam int N    = 2;
  localparam int DEB  = 4;
  localparam int MOFF = 8;
  localparam int HY   = 1;
  localparam int FA   = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         src_ok = 1'b0;
  logic         fault_clr = 1'b0;
  logic [N-1:0] s_low = '0;
  logic [N-1:0] s_high = '0;
  logic [N-1:0] pump;
  logic [N-1:0] fault;

  int n_err = 0;
  int n_chk = 0;

  // reference model state
  bit m_l1[N], m_l2[N], m_dl[N];
  bit m_h1[N], m_h2[N], m_dh[N];
  int m_lc[N], m_hc[N];
  bit m_fault[N], m_demr[N], m_run[N];
  int m_lock[N];

  controlador_bombas_param #(
    .N_TANKS   (N),
    .DEB_CYCLES(DEB),
    .MIN_OFF   (MOFF),
    .HYST      (HY),
    .FAULT_ALL (FA)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .src_ok   (src_ok),
    .s_low    (s_low),
    .s_high   (s_high),
    .fault_clr(fault_clr),
    .pump     (pump),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_l1[i] = 0; m_l2[i] = 0; m_dl[i] = 0; m_lc[i] = 0;
      m_h1[i] = 0; m_h2[i] = 0; m_dh[i] = 0; m_hc[i] = 0;
      m_fault[i] = 0; m_demr[i] = 0; m_run[i] = 0; m_lock[i] = 0;
    end
  endfunction

  function automatic logic [N-1:0] pack(input bit v[N]);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = v[i];
    return r;
  endfunction

  // One clock edge of the intended behaviour, from current inputs.
  function automatic void m_step();
    bit cond[N], fe[N], dem[N], ok[N];
    bit anyf, srcb, blkb;
    anyf = 0;
    for (int i = 0; i < N; i++) begin
      cond[i] = m_dh[i] && !m_dl[i];
      fe[i]   = m_fault[i] || cond[i];
      if (HY != 0) dem[i] = (m_demr[i] || !m_dl[i]) && !m_dh[i];
      else         dem[i] = !m_dh[i];
      if (fe[i]) anyf = 1;
    end
    for (int i = 0; i < N; i++) begin
      if (i == 0) srcb = src_ok;
      else        srcb = m_dl[i-1];
      if (FA != 0)     blkb = anyf;
      else if (i == 0) blkb = fe[i];
      else             blkb = fe[i] || fe[i-1];
      ok[i] = en && dem[i] && srcb && !blkb;
    end
    for (int i = 0; i < N; i++) begin
      if (m_run[i]) begin
        if (!ok[i]) begin
          m_run[i]  = 0;
          m_lock[i] = MOFF;
        end
      end else if (m_lock[i] > 0) begin
        m_lock[i]--;
      end else if (ok[i]) begin
        m_run[i] = 1;
      end
      m_fault[i] = cond[i] || (m_fault[i] && !fault_clr);
      m_demr[i]  = dem[i];
      if (m_l2[i] == m_dl[i]) m_lc[i] = 0;
      else if (m_lc[i] + 1 >= DEB) begin m_dl[i] = m_l2[i]; m_lc[i] = 0; end
      else m_lc[i]++;
      if (m_h2[i] == m_dh[i]) m_hc[i] = 0;
      else if (m_hc[i] + 1 >= DEB) begin m_dh[i] = m_h2[i]; m_hc[i] = 0; end
      else m_hc[i]++;
      m_l2[i] = m_l1[i]; m_l1[i] = s_low[i];
      m_h2[i] = m_h1[i]; m_h1[i] = s_high[i];
    end
  endfunction

  task automatic tick();
    m_step();
    @(posedge clk);
    @(negedge clk);
    chk("pump", pump, pack(m_run));
    chk("fault", fault, pack(m_fault));
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pump", pump, 0);
    chk("rst_fault", fault, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    chk("reset_pump", pump, 0);
    chk("reset_fault", fault, 0);
    rst_n = 1'b1; en = 1'b1; src_ok = 1'b1;
    tick();
    chk("t1_pump", pump, 2'b01);
    chk("t1_fault", fault, 2'b00);

    s_low[0] = 1'b1;
    repeat (6) tick();
    chk("t2_pre", pump, 2'b01);
    tick();
    chk("t2_pump", pump, 2'b11);

    s_high[1] = 1'b1;
    repeat (3) tick();
    s_high[1] = 1'b0;
    repeat (8) tick();
    chk("t3_glitch", pump, 2'b11);
    s_high[0] = 1'b1;
    repeat (6) tick();
    chk("t3_pre", pump, 2'b11);
    tick();
    chk("t3_drop", pump, 2'b10);
    s_high[0] = 1'b0;
    s_low[0]  = 1'b0;
    repeat (20) tick();

    s_high[1] = 1'b1;
    s_low[1]  = 1'b0;
    repeat (7) tick();
    chk("t4_fault", fault, 2'b10);
    chk("t4_pump", pump, 2'b00);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("t4_hold", fault, 2'b10);
    s_high[1] = 1'b0;
    repeat (8) tick();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("t4_clr", fault, 2'b00);
    repeat (20) tick();

    en = 1'b0;
    tick();
    chk("t5_off", pump, 2'b00);
    en = 1'b1;
    repeat (15) tick();
    do_reset();

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(9) == 0) s_low[i] = ~s_low[i];
        if ($urandom_range(11) == 0) s_high[i] = ~s_high[i];
      end
      en        = ($urandom_range(19) != 0);
      src_ok    = ($urandom_range(29) != 0);
      fault_clr = ($urandom_range(15) == 0);
      if ($urandom_range(499) == 0) do_reset();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
